// File: rtl/piso_pkg.sv
// Shared types and constants for the parallel-in/serial-out serializer.
// The optional parity bit is controlled by the PISO_PARITY_EN macro.
package piso_pkg;

    localparam int DEFAULT_WIDTH = 4;

    // PARITY is reached only when PISO_PARITY_EN is defined.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;

endpackage

// File: rtl/piso_serializer_if.sv
// Load handshake and serial output bundle for piso_serializer.
// Handshake: a word transfers on a rising edge where load_valid && load_ready;
// load_ready never depends on load_valid, and load_valid while !load_ready is ignored.
interface piso_serializer_if
    import piso_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);

    logic             load_valid;
    logic [WIDTH-1:0] load_data;
    logic             load_ready;
    logic             dout;
    logic             dout_valid;
    logic             frame_start;
    logic             busy;
    state_t           dbg_state;

    modport master (
        output load_valid,
        output load_data,
        input  load_ready,
        input  dout,
        input  dout_valid,
        input  frame_start,
        input  busy,
        input  dbg_state
    );

    modport slave (
        input  load_valid,
        input  load_data,
        output load_ready,
        output dout,
        output dout_valid,
        output frame_start,
        output busy,
        output dbg_state
    );

endinterface

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer, MSB first, back-to-back capable.
// Define PISO_PARITY_EN to append one even-parity bit after each frame.
module piso_serializer
    import piso_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic              clk,
    input  logic              rst_n,
    piso_serializer_if.slave  bus
);

    localparam int CW = $clog2(WIDTH);

    state_t            state, state_next;
    logic [CW-1:0]     cnt, cnt_next;
    // Holds only the bits still to be sent; the MSB goes straight to dout.
    logic [WIDTH-2:0]  shreg, shreg_next;
    logic              dout_q, dout_next;
    logic              valid_q, valid_next;
    logic              start_q, start_next;
    logic              busy_q, busy_next;
    logic              last_data;
    logic              transfer;
`ifdef PISO_PARITY_EN
    logic              par, par_next;
`endif

    assign last_data = (state == SHIFT) && (cnt == '0);

`ifdef PISO_PARITY_EN
    assign bus.load_ready = (state == IDLE) || (state == PARITY);
`else
    assign bus.load_ready = (state == IDLE) || last_data;
`endif

    assign transfer        = bus.load_valid && bus.load_ready;
    assign bus.dout        = dout_q;
    assign bus.dout_valid  = valid_q;
    assign bus.frame_start = start_q;
    assign bus.busy        = busy_q;
    assign bus.dbg_state   = state;

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        shreg_next = shreg;
        dout_next  = 1'b0;
        valid_next = 1'b0;
        start_next = 1'b0;
`ifdef PISO_PARITY_EN
        par_next   = par;
`endif
        unique case (state)
            IDLE: begin
                state_next = IDLE;
            end
            SHIFT: begin
                if (cnt != '0) begin
                    cnt_next   = cnt - CW'(1);
                    shreg_next = shreg << 1;
                    dout_next  = shreg[WIDTH-2];
                    valid_next = 1'b1;
                end else begin
`ifdef PISO_PARITY_EN
                    state_next = PARITY;
                    dout_next  = par;
                    valid_next = 1'b1;
`else
                    state_next = IDLE;
`endif
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        // A transfer starts a new frame, overriding the end-of-frame return to IDLE.
        if (transfer) begin
            state_next = SHIFT;
            cnt_next   = CW'(WIDTH - 1);
            shreg_next = bus.load_data[WIDTH-2:0];
            dout_next  = bus.load_data[WIDTH-1];
            valid_next = 1'b1;
            start_next = 1'b1;
`ifdef PISO_PARITY_EN
            par_next   = ^bus.load_data;
`endif
        end
        busy_next = (state_next != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            shreg   <= '0;
            dout_q  <= 1'b0;
            valid_q <= 1'b0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
`ifdef PISO_PARITY_EN
            par     <= 1'b0;
`endif
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            shreg   <= shreg_next;
            dout_q  <= dout_next;
            valid_q <= valid_next;
            start_q <= start_next;
            busy_q  <= busy_next;
`ifdef PISO_PARITY_EN
            par     <= par_next;
`endif
        end
    end

endmodule
